// File: rtl/icache_dm_pkg.sv
// Shared types for the direct-mapped instruction cache: address split, frame layout, FSM states.
package icache_dm_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned IIDX_W = 4;
  localparam int unsigned IBYT_W = 2;
  localparam int unsigned ITAG_W = WORD_W - IIDX_W - IBYT_W;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

  typedef enum logic {
    StIdle,
    StFetch
  } icstate_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_line_t;

endpackage

// File: rtl/icache_dm.sv
// Direct-mapped, one-word-per-block instruction cache: same-cycle hits, single-word fills on a miss.
// Frames live in flip-flops; hit compare, fill FSM and performance counters are all inline.
module icache_dm
  import icache_dm_pkg::*;
#(
  parameter int unsigned NFRAMES = 16,  // must equal 2**IIDX_W
  parameter int unsigned CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  input  logic             flush,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  icstate_t          state_q;
  word_t             maddr_q;
  logic              iren_q;
  word_t             iaddr_q;
  logic              flushed_q;
  logic [CNT_W-1:0]  hit_cnt_q;
  logic [CNT_W-1:0]  miss_cnt_q;
  icache_line_t      frames_q [NFRAMES];

  icachef_t     req_f;
  icachef_t     fill_f;
  icache_line_t cur_line;
  logic         hit;

  assign req_f    = icachef_t'(imemaddr);
  assign fill_f   = icachef_t'(maddr_q);
  assign cur_line = frames_q[req_f.idx];

  // nRST gating keeps ihit low during reset; flush in idle also suppresses the hit.
  assign hit = nRST & imemREN & ~flush & (state_q == StIdle) & cur_line.valid &
               (cur_line.tag == req_f.tag);

  assign ihit     = hit;
  assign imemload = hit ? cur_line.data : '0;
  assign iREN     = iren_q;
  assign iaddr    = iaddr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q    <= StIdle;
      maddr_q    <= '0;
      iren_q     <= 1'b0;
      iaddr_q    <= '0;
      flushed_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int i = 0; i < NFRAMES; i++) begin
        frames_q[i].valid <= 1'b0;
      end
    end else begin
      if (hit) begin
        hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (imemREN && !hit && !flush) begin
            state_q    <= StFetch;
            maddr_q    <= {imemaddr[31:2], 2'b00};
            iren_q     <= 1'b1;
            iaddr_q    <= {imemaddr[31:2], 2'b00};
            flushed_q  <= 1'b0;
            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
          end
        end
        StFetch: begin
          // A flush seen at any point of the fill must keep the frame from being written.
          if (flush) begin
            flushed_q <= 1'b1;
          end
          if (!iwait) begin
            state_q <= StIdle;
            iren_q  <= 1'b0;
            iaddr_q <= '0;
            if (!flush && !flushed_q) begin
              frames_q[fill_f.idx] <= '{valid: 1'b1, tag: fill_f.tag, data: iload};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (flush) begin
        for (int i = 0; i < NFRAMES; i++) begin
          frames_q[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule
